// File: rtl/fifo_arb_pkg.sv
// Shared types, constants and helpers for the FIFO write arbiter.
// Default sizing matches the standard fifo_top build (8-bit, 256 deep).
package fifo_arb_pkg;

    // Constant-foldable ceil(log2(v)); clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int depth_of(input int depth_log);
        return 1 << depth_log;
    endfunction

    // Winner/pointer width; at least one bit even for a single producer.
    function automatic int ptr_w_of(input int num_req);
        int w;
        w = clog2(num_req);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH_LOG = 8;
    localparam int DEF_NUM_REQ   = 4;

    localparam int DEPTH = depth_of(DEF_DEPTH_LOG);
    localparam int PTR_W = ptr_w_of(DEF_NUM_REQ);

    typedef logic [DEF_DEPTH_LOG:0] credit_t;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: lowest set request at or above rr_ptr,
// wrapping. Ports: req/rr_ptr/enable in; one-hot grant, winner, any_grant out.
module fifo_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               any_grant
);

    localparam int IW = PTR_W + 1;

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;
    logic [IW-1:0]        idx;

    // The request vector is doubled and the lower copy masked below
    // rr_ptr; the lowest surviving bit is the wrapped round-robin winner.
    // The upper copy is unmasked, so any nonzero req always finds a bit.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            masked[i] = dbl[i] && (i >= int'(rr_ptr));
        end

        idx = '0;
        for (int i = 2 * NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i]) idx = IW'(i);
        end

        if (idx >= IW'(NUM_REQ)) begin
            winner = PTR_W'(idx - IW'(NUM_REQ));
        end else begin
            winner = idx[PTR_W-1:0];
        end

        any_grant = enable && (|req);

        grant = '0;
        if (any_grant) grant[winner] = 1'b1;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// credit-gated by a local free-slot count tracked from the FIFO read side.
// Ports: clk, rst_n; req_valid/req_data in, req_ack out (combinational);
// fifo_write_req/fifo_write_data out (registered); fifo_full, fifo_read_req,
// fifo_empty in (observed); credit_count out (free slots).
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 8,
    parameter int NUM_REQ   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic                     fifo_write_req,
    output logic [WIDTH-1:0]         fifo_write_data,
    input  logic                     fifo_full,
    input  logic                     fifo_read_req,
    input  logic                     fifo_empty,
    output logic [DEPTH_LOG:0]       credit_count
);

    localparam int CW    = DEPTH_LOG + 1;
    localparam int PW    = ptr_w_of(NUM_REQ);
    localparam int DSIZE = depth_of(DEPTH_LOG);

    localparam logic [CW-1:0] CREDIT_MAX = CW'(DSIZE);
    localparam logic [PW-1:0] LAST_IDX   = PW'(NUM_REQ - 1);

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      winner;
    logic [NUM_REQ-1:0] grant;
    logic               any_grant;
    logic               can_grant;
    logic               rd_fire;

    assign can_grant = (credit_count != '0) && !fifo_full;
    assign rd_fire   = fifo_read_req && !fifo_empty;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .enable    (can_grant),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant)
    );

    // The ack is forced low while reset is held so no producer
    // sees a handshake the register stage is about to discard.
    assign req_ack = rst_n ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_write_req  <= 1'b0;
            fifo_write_data <= '0;
            rr_ptr          <= '0;
        end else begin
            fifo_write_req <= any_grant;
            if (any_grant) begin
                fifo_write_data <= req_data[int'(winner)*WIDTH +: WIDTH];
                rr_ptr          <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            end
        end
    end

    // Credit is debited at grant time, a cycle ahead of the physical
    // write, so a write still in the register stage is already counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_count <= CREDIT_MAX;
        end else begin
            unique case ({any_grant, rd_fire})
                2'b10: credit_count <= credit_count - 1'b1;
                2'b01: begin
                    if (credit_count != CREDIT_MAX) begin
                        credit_count <= credit_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(rd_fire && credit_count == CREDIT_MAX))
            else $error("arbiter: read fired with all credits free");
            assert (!(fifo_full && credit_count != '0))
            else $error("arbiter: fifo_full while credits remain");
        end
    end
`endif

endmodule
